// File: rtl/des_decrypt_iterative.sv
// Iterative DES decryption core: one Feistel round per clock, subkeys applied
// K16 first down to K1, with valid/ready handshakes on input and output.
module des_decrypt_iterative (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] ciphertext,
  input  logic [47:0] K1,
  input  logic [47:0] K2,
  input  logic [47:0] K3,
  input  logic [47:0] K4,
  input  logic [47:0] K5,
  input  logic [47:0] K6,
  input  logic [47:0] K7,
  input  logic [47:0] K8,
  input  logic [47:0] K9,
  input  logic [47:0] K10,
  input  logic [47:0] K11,
  input  logic [47:0] K12,
  input  logic [47:0] K13,
  input  logic [47:0] K14,
  input  logic [47:0] K15,
  input  logic [47:0] K16,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plaintext,
  output logic        busy
);

  localparam int unsigned BLK_W  = 64;
  localparam int unsigned HALF_W = 32;
  localparam int unsigned KEY_W  = 48;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(15);

  // Permutation tables use DES numbering: bit 1 is the MSB.
  localparam int unsigned IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int unsigned FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int unsigned E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int unsigned P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each S-box packed row-major (row 0 col 0 in the top nibble).
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Initial permutation.
  function automatic logic [BLK_W-1:0] des_ip(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[i])];
    return y;
  endfunction

  // Final (inverse initial) permutation.
  function automatic logic [BLK_W-1:0] des_fp(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[i])];
    return y;
  endfunction

  // Round function: expand, key-mix, S-box substitute, permute.
  function automatic logic [HALF_W-1:0] f_function(input logic [HALF_W-1:0] r,
                                                   input logic [KEY_W-1:0]  k);
    logic [KEY_W-1:0]  x;
    logic [HALF_W-1:0] s_out;
    logic [HALF_W-1:0] y;
    logic [5:0]        b;
    logic [5:0]        idx;
    x = '0;
    for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_TBL[i])];
    x = x ^ k;
    s_out = '0;
    for (int s = 0; s < 8; s++) begin
      b   = x[6'(42 - 6 * s) +: 6];
      idx = {b[5], b[0], b[4:1]};
      s_out[5'(28 - 4 * s) +: 4] = SBOX[s][8'(252 - 4 * int'(idx)) +: 4];
    end
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = s_out[5'(32 - P_TBL[i])];
    return y;
  endfunction

  state_t             state_q, state_d;
  logic [HALF_W-1:0]  l_q, l_d;
  logic [HALF_W-1:0]  r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   round_key;
  logic [HALF_W-1:0]  f_out;
  logic [BLK_W-1:0]   ct_ip;

  assign ct_ip     = des_ip(ciphertext);
  assign f_out     = f_function(r_q, round_key);
  assign plaintext = des_fp({r_q, l_q});

  // Reverse-order key select: round 0 uses K16, round 15 uses K1.
  always_comb begin
    round_key = K16;
    case (cnt_q)
      4'd0:  round_key = K16;
      4'd1:  round_key = K15;
      4'd2:  round_key = K14;
      4'd3:  round_key = K13;
      4'd4:  round_key = K12;
      4'd5:  round_key = K11;
      4'd6:  round_key = K10;
      4'd7:  round_key = K9;
      4'd8:  round_key = K8;
      4'd9:  round_key = K7;
      4'd10: round_key = K6;
      4'd11: round_key = K5;
      4'd12: round_key = K4;
      4'd13: round_key = K3;
      4'd14: round_key = K2;
      4'd15: round_key = K1;
    endcase
  end

  // State, half-block and round-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, datapath update and handshake decode.
  always_comb begin
    state_d   = state_q;
    l_d       = l_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          l_d     = ct_ip[63:32];
          r_d     = ct_ip[31:0];
          cnt_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        busy  = 1'b1;
        l_d   = r_q;
        r_d   = l_q ^ f_out;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ROUND) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_des_decrypt_iterative.sv
// Directed-vector bench for des_decrypt_iterative using published DES vectors.
module tb_des_decrypt_iterative;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ciphertext;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] plaintext;
  logic        busy;
  logic [47:0] ks [16];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = -1;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT_A  = 64'h85E813540F0AB405;
  localparam logic [63:0] PT_A  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY_B = 64'h0000000000000000;
  localparam logic [63:0] CT_B  = 64'h8CA64DE9C1B123A7;
  localparam logic [63:0] PT_B  = 64'h0000000000000000;
  localparam logic [63:0] KEY_C = 64'h0E329232EA6D0D73;
  localparam logic [63:0] CT_C  = 64'h0000000000000000;
  localparam logic [63:0] PT_C  = 64'h8787878787878787;
  localparam logic [63:0] KEY_D = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT_D  = 64'h3FA40E8A984D4815;
  localparam logic [63:0] PT_D  = 64'h4E6F772069732074;

  des_decrypt_iterative dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .K1  (ks[0]),  .K2  (ks[1]),  .K3  (ks[2]),  .K4  (ks[3]),
    .K5  (ks[4]),  .K6  (ks[5]),  .K7  (ks[6]),  .K8  (ks[7]),
    .K9  (ks[8]),  .K10 (ks[9]),  .K11 (ks[10]), .K12 (ks[11]),
    .K13 (ks[12]), .K14 (ks[13]), .K15 (ks[14]), .K16 (ks[15]),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // DES key schedule: PC-1, per-round left rotations, PC-2.
  task automatic load_keys(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] sub;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1[i])];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) sub[6'(47 - j)] = cd[6'(56 - PC2[j])];
      ks[r] = sub;
    end
  endtask

  // Push one block through with out_ready high; called at a falling edge.
  task automatic run_block(input string tag, input logic [63:0] key, input logic [63:0] ct,
                           input logic [63:0] exp, input bit disturb, input bit chk_period);
    int waitc;
    int lat;
    int acc;
    load_keys(key);
    ciphertext = ct;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    acc = cyc + 1;
    if (chk_period && last_acc >= 0) check({tag, " period"}, 64'(acc - last_acc), 64'd18);
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " busy"}, 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (disturb) begin
        in_valid   = (lat % 2 == 0);
        ciphertext = {$urandom, $urandom};
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'd16);
    check({tag, " plaintext"}, plaintext, exp);
    check({tag, " in_ready in DONE"}, 64'(in_ready), 64'd0);
    @(negedge clk);
    check({tag, " out_valid after hs"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready after hs"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int waitc;
    int lat;
    rst_n      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ciphertext = '0;
    load_keys(64'h0);

    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset plaintext", plaintext, 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer vectors back to back, then busy-time input disturbance.
    run_block("std", KEY_A, CT_A, PT_A, 1'b0, 1'b0);
    run_block("zero_key", KEY_B, CT_B, PT_B, 1'b0, 1'b1);
    run_block("vec_c", KEY_C, CT_C, PT_C, 1'b0, 1'b1);
    run_block("now_is_t", KEY_D, CT_D, PT_D, 1'b0, 1'b1);
    run_block("ignore_busy", KEY_A, CT_A, PT_A, 1'b1, 1'b1);

    // Backpressure: stall in DONE with in_valid toggling.
    load_keys(KEY_A);
    ciphertext = CT_A;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp latency", 64'(lat), 64'd16);
    for (int i = 0; i < 10; i++) begin
      in_valid   = (i % 2 == 0);
      ciphertext = {$urandom, $urandom};
      @(negedge clk);
      check("bp plaintext", plaintext, PT_A);
      check("bp out_valid", 64'(out_valid), 64'd1);
      check("bp in_ready", 64'(in_ready), 64'd0);
      check("bp busy", 64'(busy), 64'd0);
    end
    // Input and output handshakes offered together: only the output one fires.
    in_valid   = 1'b1;
    ciphertext = CT_A;
    out_ready  = 1'b1;
    @(negedge clk);
    check("bp release in_ready", 64'(in_ready), 64'd1);
    check("bp release out_valid", 64'(out_valid), 64'd0);
    check("bp release busy", 64'(busy), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp next accept busy", 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp next latency", 64'(lat), 64'd16);
    check("bp next plaintext", plaintext, PT_A);
    @(negedge clk);
    check("bp next in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of the rounds.
    load_keys(KEY_D);
    ciphertext = CT_D;
    in_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst busy before", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst plaintext", plaintext, 64'h0);
    @(negedge clk);
    @(negedge clk);
    check("midrst held out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_block("after_rst", KEY_C, CT_C, PT_C, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
